// File: rtl/riscv_core_icache_pkg.sv
// Shared definitions for the instruction-cache refill path: FSM state encoding
// and the AXI/line constants used when building refill bursts.
package riscv_core_icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_DONE = 2'd3
  } refill_state_e;

  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam int         LINE_OFFSET_W = 5;

endpackage

// File: rtl/riscv_core_icache_refill_axi.sv
// Instruction-cache line refill engine: issues one INCR AXI read burst per
// request and assembles the returned beats into a full cache line.
module riscv_core_icache_refill_axi
  import riscv_core_icache_pkg::*;
#(
  parameter int ADDR_WIDTH     = 64,
  parameter int LINE_WIDTH     = 256,
  parameter int AXI_DATA_WIDTH = 64
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_mem_req,
  input  logic [ADDR_WIDTH-1:0]     i_mem_addr,
  output logic                      o_mem_done,
  output logic                      o_mem_err,
  output logic [LINE_WIDTH-1:0]     o_line,
  output logic                      o_arvalid,
  input  logic                      i_arready,
  output logic [ADDR_WIDTH-1:0]     o_araddr,
  output logic [7:0]                o_arlen,
  output logic [2:0]                o_arsize,
  output logic [1:0]                o_arburst,
  input  logic                      i_rvalid,
  output logic                      o_rready,
  input  logic [AXI_DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]                i_rresp,
  input  logic                      i_rlast
);

  localparam int BEATS = LINE_WIDTH / AXI_DATA_WIDTH;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int SIZE  = $clog2(AXI_DATA_WIDTH / 8);

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~{{(ADDR_WIDTH - LINE_OFFSET_W){1'b0}}, {LINE_OFFSET_W{1'b1}}};

  refill_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [CNT_W-1:0]        beat_q, beat_d;
  logic                    err_q, err_d;
  logic [LINE_WIDTH-1:0]   line_q, line_d;

  logic last_beat;
  logic beat_fire;

  assign last_beat = (beat_q == CNT_W'(BEATS - 1));
  assign beat_fire = (state_q == ST_R) && i_rvalid;

  assign o_arlen   = 8'(BEATS - 1);
  assign o_arsize  = 3'(SIZE);
  assign o_arburst = BURST_INCR;
  assign o_araddr  = araddr_q;
  assign o_line    = line_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      araddr_q <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
      line_q   <= '0;
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
      line_q   <= line_d;
    end
  end

  // Early RLAST also ends the burst; untouched line slots keep old data.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_mem_req) state_d = ST_AR;
      ST_AR:   if (i_arready) state_d = ST_R;
      ST_R:    if (i_rvalid && (last_beat || i_rlast)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_arvalid  = 1'b0;
    o_rready   = 1'b0;
    o_mem_done = 1'b0;
    o_mem_err  = 1'b0;
    case (state_q)
      ST_AR:   o_arvalid = 1'b1;
      ST_R:    o_rready  = 1'b1;
      ST_DONE: begin
        o_mem_done = 1'b1;
        o_mem_err  = err_q;
      end
      default: ;
    endcase
  end

  // Any bad response or RLAST misplacement marks the whole refill as failed.
  always_comb begin
    araddr_d = araddr_q;
    beat_d   = beat_q;
    err_d    = err_q;
    line_d   = line_q;
    if (state_q == ST_IDLE && i_mem_req) begin
      araddr_d = i_mem_addr & LINE_MASK;
      beat_d   = '0;
      err_d    = 1'b0;
    end
    if (beat_fire) begin
      for (int k = 0; k < BEATS; k++) begin
        if (beat_q == CNT_W'(k)) line_d[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = i_rdata;
      end
      if (!last_beat) beat_d = beat_q + 1'b1;
      if ((i_rresp != RESP_OKAY) || (i_rlast && !last_beat) || (!i_rlast && last_beat))
        err_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_riscv_core_icache_refill_axi.sv
// Directed bench for the icache refill engine: drives AXI read responses by
// hand and checks addresses, timing, assembled lines and error reporting.
module tb_riscv_core_icache_refill_axi;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_mem_req;
  logic [63:0]  i_mem_addr;
  logic         o_mem_done;
  logic         o_mem_err;
  logic [255:0] o_line;
  logic         o_arvalid;
  logic         i_arready;
  logic [63:0]  o_araddr;
  logic [7:0]   o_arlen;
  logic [2:0]   o_arsize;
  logic [1:0]   o_arburst;
  logic         i_rvalid;
  logic         o_rready;
  logic [63:0]  i_rdata;
  logic [1:0]   i_rresp;
  logic         i_rlast;

  int checks   = 0;
  int failures = 0;
  logic [255:0] line_model = '0;

  riscv_core_icache_refill_axi dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_mem_req  (i_mem_req),
    .i_mem_addr (i_mem_addr),
    .o_mem_done (o_mem_done),
    .o_mem_err  (o_mem_err),
    .o_line     (o_line),
    .o_arvalid  (o_arvalid),
    .i_arready  (i_arready),
    .o_araddr   (o_araddr),
    .o_arlen    (o_arlen),
    .o_arsize   (o_arsize),
    .o_arburst  (o_arburst),
    .i_rvalid   (i_rvalid),
    .o_rready   (o_rready),
    .i_rdata    (i_rdata),
    .i_rresp    (i_rresp),
    .i_rlast    (i_rlast)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [63:0] beat_data(input int t, input int k);
    return {16'hDA7A, 8'(t), 8'(k), 32'h0BAD_F00D ^ (32'(t) << 4) ^ 32'(k)};
  endfunction

  // last_at < 0: RLAST on beat 3; 0..3: RLAST on that beat; >3: RLAST never.
  task automatic refill(input int t, input logic [63:0] addr, input int ar_delay,
                        input int gap, input int bad_beat, input int last_at,
                        input bit keep_req, input logic exp_err,
                        output int ar_wait, output int lat);
    logic [63:0]  exp_addr;
    logic [255:0] exp_line;
    int nb;
    int cyc;
    exp_addr = addr & ~64'h1f;
    exp_line = line_model;
    nb = (last_at >= 0 && last_at < 4) ? last_at + 1 : 4;
    i_mem_req  = 1'b1;
    i_mem_addr = addr;
    cyc = 0;
    ar_wait = 0;
    lat = 0;
    while (!o_arvalid && ar_wait < 20) begin
      step;
      cyc++;
      ar_wait++;
    end
    chk("arvalid_up", o_arvalid, 1'b1);
    if (!o_arvalid) begin
      i_mem_req = 1'b0;
      return;
    end
    chk("araddr", o_araddr, exp_addr);
    i_mem_addr = ~addr;
    for (int d = 0; d < ar_delay; d++) begin
      step;
      cyc++;
      chk("arvalid_hold", o_arvalid, 1'b1);
      chk("araddr_hold", o_araddr, exp_addr);
    end
    i_arready = 1'b1;
    step;
    cyc++;
    i_arready = 1'b0;
    chk("arvalid_drop", o_arvalid, 1'b0);
    for (int k = 0; k < nb; k++) begin
      if (k > 0) begin
        for (int g = 0; g < gap; g++) begin
          step;
          cyc++;
          chk("rready_gap", o_rready, 1'b1);
          chk("no_early_done", o_mem_done, 1'b0);
        end
      end
      chk("rready", o_rready, 1'b1);
      i_rvalid = 1'b1;
      i_rdata  = beat_data(t, k);
      i_rresp  = (k == bad_beat) ? 2'b10 : 2'b00;
      i_rlast  = (k == last_at) || (last_at < 0 && k == 3);
      exp_line[k*64 +: 64] = beat_data(t, k);
      step;
      cyc++;
      i_rvalid = 1'b0;
      i_rlast  = 1'b0;
      i_rresp  = 2'b00;
    end
    lat = cyc;
    chk("done", o_mem_done, 1'b1);
    chk("err", o_mem_err, exp_err);
    chk("line", o_line, exp_line);
    chk("rready_off", o_rready, 1'b0);
    line_model = exp_line;
    if (!keep_req) begin
      i_mem_req = 1'b0;
      step;
      chk("done_pulse", o_mem_done, 1'b0);
      chk("err_clear", o_mem_err, 1'b0);
      chk("line_hold", o_line, exp_line);
      chk("idle_arvalid", o_arvalid, 1'b0);
    end
  endtask

  int ar_wait;
  int lat;

  initial begin
    i_rst      = 1'b1;
    i_mem_req  = 1'b0;
    i_mem_addr = '0;
    i_arready  = 1'b0;
    i_rvalid   = 1'b0;
    i_rdata    = '0;
    i_rresp    = 2'b00;
    i_rlast    = 1'b0;
    step;
    step;
    i_rst = 1'b0;

    chk("rst_arvalid", o_arvalid, 1'b0);
    chk("rst_rready", o_rready, 1'b0);
    chk("rst_done", o_mem_done, 1'b0);
    chk("rst_err", o_mem_err, 1'b0);
    chk("rst_araddr", o_araddr, 64'h0);
    chk("rst_line", o_line, 256'h0);
    chk("arlen", o_arlen, 8'd3);
    chk("arsize", o_arsize, 3'b011);
    chk("arburst", o_arburst, 2'b01);

    refill(1, 64'h0000_0000_0000_1234, 0, 0, -1, -1, 1'b0, 1'b0, ar_wait, lat);
    chk("zw_ar_wait", 32'(ar_wait), 32'd1);
    chk("zw_latency", 32'(lat), 32'd6);
    chk("zw_line_lit", o_line, {64'hDA7A_0103_0BAD_F01E, 64'hDA7A_0102_0BAD_F01F,
                                64'hDA7A_0101_0BAD_F01C, 64'hDA7A_0100_0BAD_F01D});

    refill(2, 64'h0000_0000_8000_00FF, 5, 2, -1, -1, 1'b0, 1'b0, ar_wait, lat);
    chk("slow_araddr_final", o_araddr, 64'h0000_0000_8000_00E0);

    refill(3, 64'h0000_0000_0000_4040, 0, 0, 2, -1, 1'b0, 1'b1, ar_wait, lat);

    refill(4, 64'h0000_0000_0000_5000, 0, 1, -1, 1, 1'b0, 1'b1, ar_wait, lat);
    chk("early_last_upper", o_line[255:128],
        {beat_data(3, 3), beat_data(3, 2)});

    refill(5, 64'h0000_0000_0000_6010, 0, 0, -1, 99, 1'b0, 1'b1, ar_wait, lat);

    i_mem_req  = 1'b1;
    i_mem_addr = 64'h0000_0000_0000_2000;
    step;
    chk("rstR_arvalid", o_arvalid, 1'b1);
    i_arready = 1'b1;
    step;
    i_arready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_rvalid = 1'b1;
      i_rdata  = beat_data(6, k);
      i_rlast  = 1'b0;
      step;
    end
    i_rdata = beat_data(6, 2);
    i_rst   = 1'b1;
    step;
    i_rst     = 1'b0;
    i_rvalid  = 1'b0;
    i_mem_req = 1'b0;
    chk("rstR_rready", o_rready, 1'b0);
    chk("rstR_done", o_mem_done, 1'b0);
    chk("rstR_arvalid_off", o_arvalid, 1'b0);
    chk("rstR_line", o_line, 256'h0);
    chk("rstR_araddr", o_araddr, 64'h0);
    line_model = '0;
    for (int c = 0; c < 3; c++) begin
      step;
      chk("rstR_quiet_done", o_mem_done, 1'b0);
    end
    refill(7, 64'h0000_0000_0000_3000, 0, 0, -1, -1, 1'b0, 1'b0, ar_wait, lat);
    chk("post_rst_latency", 32'(lat), 32'd6);

    refill(8, 64'h0000_0000_0000_1000, 0, 0, -1, -1, 1'b1, 1'b0, ar_wait, lat);
    refill(9, 64'h0000_0000_0000_1020, 0, 0, -1, -1, 1'b0, 1'b0, ar_wait, lat);
    chk("b2b_ar_wait", 32'(ar_wait), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
